// File: rtl/systolic_skew_fifo_if.sv
// Operand-loader <-> skew FIFO bus. The loader (master) drives row pushes, pops
// and flushes; the FIFO (slave) returns the skewed lanes and its queue status.
interface systolic_skew_fifo_if #(
    parameter int ARRAY_DIM = 4,
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 4
);
    localparam int ROW_W = DATA_W * ARRAY_DIM;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // load and shift are requests sampled on every rising edge; there is no
    // ready return. A request the FIFO cannot honour is dropped and flagged on
    // err during the following cycle, and full/empty/count show the outcome.
    logic                 load;
    logic [ROW_W-1:0]     load_values;
    logic                 shift;
    logic                 clear;
    logic [ROW_W-1:0]     out;
    logic [ARRAY_DIM-1:0] out_valid;
    logic [CNT_W-1:0]     count;
    logic                 full;
    logic                 empty;
    logic                 busy;
    logic                 err;

    modport master (
        output load, load_values, shift, clear,
        input  out, out_valid, count, full, empty, busy, err
    );

    modport slave (
        input  load, load_values, shift, clear,
        output out, out_valid, count, full, empty, busy, err
    );
endinterface

// File: rtl/systolic_skew_fifo.sv
// Row queue for one systolic-array operand edge: buffers whole rows and emits
// each popped row as a diagonal, lane k delayed k cycles behind lane 0.
module systolic_skew_fifo #(
    parameter int ARRAY_DIM = 4,
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 4
) (
    input logic              CLK,
    input logic              nRST,
    systolic_skew_fifo_if.slave bus
);
    localparam int ROW_W = DATA_W * ARRAY_DIM;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ROW_W-1:0]     rows [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count_q;
    logic                 err_q;
    logic                 full_w;
    logic                 empty_w;
    logic                 pop_ok;
    logic                 push_ok;
    logic                 err_next;
    logic [ROW_W-1:0]     pop_row;
    logic [ROW_W-1:0]     out_w;
    logic [ARRAY_DIM-1:0] valid_w;
    logic [ARRAY_DIM-1:0] lane_busy;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_w  = (count_q == CNT_W'(DEPTH));
    assign empty_w = (count_q == '0);

    // A pop frees a slot in the same edge, so a full queue still takes a push
    // alongside a pop; an empty queue never forwards the incoming row.
    always_comb begin
        pop_ok   = 1'b0;
        push_ok  = 1'b0;
        err_next = 1'b0;
        if (!bus.clear) begin
            pop_ok   = bus.shift && !empty_w;
            push_ok  = bus.load && (!full_w || pop_ok);
            err_next = (bus.load && !push_ok) || (bus.shift && empty_w);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else if (bus.clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= err_next;
            if (push_ok) wr_ptr <= next_ptr(wr_ptr);
            if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Row storage needs no reset: a slot is only read after it was written.
    always_ff @(posedge CLK) begin
        if (push_ok) rows[wr_ptr] <= bus.load_values;
    end

    assign pop_row = rows[rd_ptr];

    for (genvar k = 0; k < ARRAY_DIM; k++) begin : g_lane
        logic [DATA_W-1:0] stage_data [0:k];
        logic [k:0]        stage_valid;

        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                for (int j = 0; j <= k; j++) stage_data[j] <= '0;
                stage_valid <= '0;
            end else if (bus.clear) begin
                for (int j = 0; j <= k; j++) stage_data[j] <= '0;
                stage_valid <= '0;
            end else begin
                stage_data[0]  <= pop_ok ? pop_row[k*DATA_W +: DATA_W] : '0;
                stage_valid[0] <= pop_ok;
                for (int j = 1; j <= k; j++) begin
                    stage_data[j]  <= stage_data[j-1];
                    stage_valid[j] <= stage_valid[j-1];
                end
            end
        end

        assign out_w[k*DATA_W +: DATA_W] = stage_data[k];
        assign valid_w[k]                = stage_valid[k];
        assign lane_busy[k]              = |stage_valid;
    end

    assign bus.out       = out_w;
    assign bus.out_valid = valid_w;
    assign bus.count     = count_q;
    assign bus.full      = full_w;
    assign bus.empty     = empty_w;
    assign bus.busy      = |lane_busy;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_systolic_skew_fifo.sv
// Drives a DEPTH=4 and a DEPTH=3 instance with identical stimulus and checks
// both against a row-queue / pop-history reference model.
module tb_systolic_skew_fifo;
    localparam int AD     = 4;
    localparam int DW     = 16;
    localparam int W      = AD * DW;
    localparam int MAXCYC = 1024;

    logic         CLK;
    logic         nRST;
    logic         ld;
    logic         sh;
    logic         clr;
    logic [W-1:0] vals;

    systolic_skew_fifo_if #(.ARRAY_DIM(AD), .DATA_W(DW), .DEPTH(4)) bus_a ();
    systolic_skew_fifo_if #(.ARRAY_DIM(AD), .DATA_W(DW), .DEPTH(3)) bus_b ();

    assign bus_a.load        = ld;
    assign bus_a.load_values = vals;
    assign bus_a.shift       = sh;
    assign bus_a.clear       = clr;
    assign bus_b.load        = ld;
    assign bus_b.load_values = vals;
    assign bus_b.shift       = sh;
    assign bus_b.clear       = clr;

    systolic_skew_fifo #(.ARRAY_DIM(AD), .DATA_W(DW), .DEPTH(4)) dut_a (
        .CLK(CLK), .nRST(nRST), .bus(bus_a)
    );
    systolic_skew_fifo #(.ARRAY_DIM(AD), .DATA_W(DW), .DEPTH(3)) dut_b (
        .CLK(CLK), .nRST(nRST), .bus(bus_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // reference model: queued rows, per-edge pop history, registered err
    logic [W-1:0] q0 [$];
    logic [W-1:0] q1 [$];
    bit           hpop [2][MAXCYC];
    logic [W-1:0] hrow [2][MAXCYC];
    int           vfrom [2];
    bit           err_e [2];
    int           cyc;
    int           n_checks;
    int           n_fail;

    function automatic logic [W-1:0] mkrow(input int a, input int b, input int c, input int d);
        return {DW'(d), DW'(c), DW'(b), DW'(a)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input int d, input int n);
        int sz;
        int dep;
        bit pop;
        bit push;
        sz  = (d == 0) ? q0.size() : q1.size();
        dep = (d == 0) ? 4 : 3;
        hpop[d][n] = 1'b0;
        hrow[d][n] = '0;
        if (clr) begin
            if (d == 0) q0.delete(); else q1.delete();
            err_e[d] = 1'b0;
            vfrom[d] = n;
        end else begin
            pop      = sh && (sz > 0);
            push     = ld && ((sz < dep) || pop);
            err_e[d] = (ld && !push) || (sh && (sz == 0));
            if (pop) begin
                hpop[d][n] = 1'b1;
                hrow[d][n] = (d == 0) ? q0.pop_front() : q1.pop_front();
            end
            if (push) begin
                if (d == 0) q0.push_back(vals); else q1.push_back(vals);
            end
        end
    endtask

    task automatic check_dut(input int d, input int n);
        logic [W-1:0]  e_out;
        logic [AD-1:0] e_v;
        bit            e_busy;
        int            sz;
        int            dep;
        int            m;
        logic [W-1:0]  o_out;
        logic [AD-1:0] o_v;
        logic [63:0]   o_cnt;
        logic          o_full, o_empty, o_busy, o_err;
        e_out  = '0;
        e_v    = '0;
        e_busy = 1'b0;
        sz  = (d == 0) ? q0.size() : q1.size();
        dep = (d == 0) ? 4 : 3;
        for (int k = 0; k < AD; k++) begin
            m = n - k;
            if (m >= 0 && m >= vfrom[d] && hpop[d][m]) begin
                e_out[k*DW +: DW] = hrow[d][m][k*DW +: DW];
                e_v[k]            = 1'b1;
                e_busy            = 1'b1;
            end
        end
        if (d == 0) begin
            o_out = bus_a.out; o_v = bus_a.out_valid; o_cnt = 64'(bus_a.count);
            o_full = bus_a.full; o_empty = bus_a.empty; o_busy = bus_a.busy; o_err = bus_a.err;
        end else begin
            o_out = bus_b.out; o_v = bus_b.out_valid; o_cnt = 64'(bus_b.count);
            o_full = bus_b.full; o_empty = bus_b.empty; o_busy = bus_b.busy; o_err = bus_b.err;
        end
        chk($sformatf("dut%0d cyc%0d out", d, n), o_out, e_out);
        chk($sformatf("dut%0d cyc%0d out_valid", d, n), 64'(o_v), 64'(e_v));
        chk($sformatf("dut%0d cyc%0d count", d, n), o_cnt, 64'(sz));
        chk($sformatf("dut%0d cyc%0d full", d, n), 64'(o_full), 64'(sz == dep));
        chk($sformatf("dut%0d cyc%0d empty", d, n), 64'(o_empty), 64'(sz == 0));
        chk($sformatf("dut%0d cyc%0d busy", d, n), 64'(o_busy), 64'(e_busy));
        chk($sformatf("dut%0d cyc%0d err", d, n), 64'(o_err), 64'(err_e[d]));
    endtask

    task automatic step(input bit l, input logic [W-1:0] v, input bit s, input bit c);
        ld = l; vals = v; sh = s; clr = c;
        @(posedge CLK);
        if (cyc >= MAXCYC) begin
            n_fail++;
            $display("FAIL cycle_budget observed=%0d required<%0d", cyc, MAXCYC);
            $fatal(1, "cycle budget exhausted");
        end
        model_edge(0, cyc);
        model_edge(1, cyc);
        #1;
        check_dut(0, cyc);
        check_dut(1, cyc);
        cyc++;
        ld = 1'b0; sh = 1'b0; clr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic rst_check(input string tag);
        chk({tag, " a.out"},       bus_a.out, '0);
        chk({tag, " a.out_valid"}, 64'(bus_a.out_valid), 64'(0));
        chk({tag, " a.count"},     64'(bus_a.count), 64'(0));
        chk({tag, " a.full"},      64'(bus_a.full), 64'(0));
        chk({tag, " a.empty"},     64'(bus_a.empty), 64'(1));
        chk({tag, " a.busy"},      64'(bus_a.busy), 64'(0));
        chk({tag, " a.err"},       64'(bus_a.err), 64'(0));
        chk({tag, " b.out"},       bus_b.out, '0);
        chk({tag, " b.out_valid"}, 64'(bus_b.out_valid), 64'(0));
        chk({tag, " b.count"},     64'(bus_b.count), 64'(0));
        chk({tag, " b.empty"},     64'(bus_b.empty), 64'(1));
        chk({tag, " b.busy"},      64'(bus_b.busy), 64'(0));
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        err_e[0] = 1'b0;
        err_e[1] = 1'b0;
        vfrom[0] = cyc;
        vfrom[1] = cyc;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        nRST = 1'b0; ld = 1'b0; sh = 1'b0; clr = 1'b0; vals = '0;
        model_reset();
        #3;
        rst_check("reset");
        @(posedge CLK);
        @(posedge CLK);
        #1 nRST = 1'b1;

        // fill, overflow push, then drain four rows back to back
        for (int i = 0; i < 4; i++) step(1'b1, mkrow(4*i+1, 4*i+2, 4*i+3, 4*i+4), 1'b0, 1'b0);
        step(1'b1, mkrow(17, 18, 19, 20), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
        idle(5);

        // push+pop while full, pointer wrap over ten iterations
        for (int i = 0; i < 4; i++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, {$urandom, $urandom}, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
        idle(4);

        // pop on empty, then push+pop on empty
        step(1'b0, '0, 1'b1, 1'b0);
        idle(1);
        step(1'b1, mkrow(21, 22, 23, 24), 1'b1, 1'b0);
        idle(4);
        step(1'b0, '0, 1'b1, 1'b0);
        idle(4);

        // clear mid-drain alongside a push
        for (int i = 0; i < 3; i++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, {$urandom, $urandom}, 1'b0, 1'b1);
        idle(4);

        // asynchronous reset between edges while rows are draining
        step(1'b1, mkrow(31, 32, 33, 34), 1'b0, 1'b0);
        step(1'b1, mkrow(35, 36, 37, 38), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        #2 nRST = 1'b0;
        #1;
        rst_check("async_reset");
        model_reset();
        @(posedge CLK);
        @(posedge CLK);
        #1 nRST = 1'b1;
        step(1'b1, mkrow(1, 2, 3, 4), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        idle(4);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 99) < 55, {$urandom, $urandom},
                 $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 4);
        end
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
